writeback_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  ALU results and load data returning from memory.

---
 rtl/writeback_arbiter.sv | 103 ++++++++++
 tb/tb_writeback_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write-port arbiter for ALU and load writebacks
// Memory has priority; a run of memory grants with the ALU waiting boosts the ALU.
module writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  aluValid,
   input  logic [ADDR_WIDTH-1:0] aluReg,
   input  logic [DATA_WIDTH-1:0] aluData,
   output logic                  aluReady,
   input  logic                  memValid,
   input  logic [ADDR_WIDTH-1:0] memReg,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic                  memReady,
   output logic                  regWrite,
   output logic [ADDR_WIDTH-1:0] writeReg,
   output logic [DATA_WIDTH-1:0] writeData
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic {NORMAL, BOOST} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
   logic                  reg_write_q, reg_write_d;
   logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic                  alu_grant, mem_grant;

   always_comb begin
      alu_grant = 1'b0;
      mem_grant = 1'b0;
      if (!reset && !stall) begin
         if (state_q == BOOST) begin
            if (aluValid)      alu_grant = 1'b1;
            else if (memValid) mem_grant = 1'b1;
         end else begin
            if (memValid)      mem_grant = 1'b1;
            else if (aluValid) alu_grant = 1'b1;
         end
      end
   end

   assign aluReady = alu_grant;
   assign memReady = mem_grant;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      if (!stall) begin
         if (alu_grant || !aluValid) begin
            starve_cnt_d = '0;
            state_d      = NORMAL;
         end else if (mem_grant) begin
            // ALU is waiting behind this memory grant
            if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
            if (starve_cnt_q == LIMIT - 1'b1) state_d = BOOST;
         end
      end

      // x0 targets are accepted but never reach the write port
      if (alu_grant) begin
         reg_write_d  = (aluReg != '0);
         write_reg_d  = aluReg;
         write_data_d = aluData;
      end else if (mem_grant) begin
         reg_write_d  = (memReg != '0);
         write_reg_d  = memReg;
         write_data_d = memData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= NORMAL;
         starve_cnt_q <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign regWrite  = reg_write_q;
   assign writeReg  = write_reg_q;
   assign writeData = write_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
// Vectors carry the hand-derived grant; expected ready and write are queued per cycle.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        aluValid = 1'b0;
   logic [4:0]  aluReg = '0;
   logic [31:0] aluData = '0;
   logic        aluReady;
   logic        memValid = 1'b0;
   logic [4:0]  memReg = '0;
   logic [31:0] memData = '0;
   logic        memReady;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;

   writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
      .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [1:0] rdy;} rdy_t;
   typedef struct {int cyc; logic rw; logic [4:0] r; logic [31:0] d;} out_t;

   rdy_t rq[$];
   out_t oq[$];
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   logic [4:0]  last_reg = '0;
   logic [31:0] last_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // g: 0 = no grant, 1 = ALU, 2 = memory
   task automatic step(input logic rst, input logic st,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input int g);
      rdy_t re;
      out_t oe;
      @(posedge clk);
      #2;
      reset = rst; stall = st;
      aluValid = av; aluReg = ar; aluData = ad;
      memValid = mv; memReg = mr; memData = md;
      re.cyc = cyc;
      re.rdy = {g == 1, g == 2};
      rq.push_back(re);
      oe.cyc = cyc + 1;
      oe.rw  = 1'b0;
      if (rst) begin
         last_reg = '0; last_data = '0;
      end else if (g == 1) begin
         oe.rw = (ar != 0); last_reg = ar; last_data = ad;
      end else if (g == 2) begin
         oe.rw = (mr != 0); last_reg = mr; last_data = md;
      end
      oe.r = last_reg;
      oe.d = last_data;
      oq.push_back(oe);
   endtask

   initial begin
      rdy_t re;
      out_t oe;
      forever begin
         @(negedge clk);
         while (rq.size() > 0 && rq[0].cyc == cyc) begin
            re = rq.pop_front();
            tests++;
            if ({aluReady, memReady} !== re.rdy) begin
               fails++;
               $display("FAIL ready cyc=%0d {alu,mem} got=%b exp=%b", cyc, {aluReady, memReady}, re.rdy);
            end
         end
         while (oq.size() > 0 && oq[0].cyc == cyc) begin
            oe = oq.pop_front();
            tests++;
            if ({regWrite, writeReg, writeData} !== {oe.rw, oe.r, oe.d}) begin
               fails++;
               $display("FAIL write cyc=%0d got rw=%b reg=%0d data=%h exp rw=%b reg=%0d data=%h",
                        cyc, regWrite, writeReg, writeData, oe.rw, oe.r, oe.d);
            end
         end
      end
   end

   initial begin
      logic [31:0] a_d;
      // reset with both sources requesting
      step(1, 0, 1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB, 0);
      step(1, 0, 1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB, 0);
      // single ALU write, then idle
      step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1);
      step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
      step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
      // contention: M,M,M,M,A,M,M,M,M,A
      a_d = 32'hA0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 5'd6, a_d, 1, 5'(1 + i % 7), 32'h100 + i, (i == 4 || i == 9) ? 1 : 2);
         if (i == 4) a_d = 32'hA1;
      end
      // x0 drop
      step(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'd7, 2);
      // build starveCnt to 3, stall, then memory reaches the limit and ALU wins
      for (int i = 0; i < 3; i++) step(0, 0, 1, 5'd6, 32'hC0, 1, 5'd8, 32'h200 + i, 2);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd6, 32'hC0, 1, 5'd8, 32'h210, 0);
      step(0, 0, 1, 5'd6, 32'hC0, 1, 5'd8, 32'h220, 2);
      step(0, 0, 1, 5'd6, 32'hC0, 1, 5'd8, 32'h221, 1);
      // reset mid-write
      step(0, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 2);
      step(1, 0, 1, 5'd11, 32'h11, 1, 5'd10, 32'h10, 0);
      step(0, 0, 1, 5'd11, 32'h11, 1, 5'd10, 32'h10, 2);
      step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
      step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
      repeat (3) @(posedge clk);
      tests++;
      if (rq.size() != 0 || oq.size() != 0) begin
         fails++;
         $display("FAIL drain got=%0d/%0d pending exp=0/0", rq.size(), oq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
